// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes, iterative shifts and an optional
// shift-add multiplier enabled by defining SEQ_ALU_MUL_EN.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_cmd,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             sc_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rslt,
  output logic             sc_o,
  output logic             pari,
  output logic             zero
);

  localparam logic [2:0] CMD_ADD  = 3'b000;
  localparam logic [2:0] CMD_SHL  = 3'b001;
  localparam logic [2:0] CMD_SHR  = 3'b010;
  localparam logic [2:0] CMD_NAND = 3'b011;
  localparam logic [2:0] CMD_SUB  = 3'b100;
  localparam logic [2:0] CMD_MUL  = 3'b101;
  localparam logic [2:0] CMD_XOR  = 3'b110;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             sci_q, sci_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] rslt_q, rslt_d;
  logic             sco_q, sco_d;
  logic             pari_q, pari_d;
  logic             zero_q, zero_d;

  logic             idle;
  logic [2:0]       w_cmd;
  logic [WIDTH-1:0] w_a;
  logic             w_sci;
  logic [WIDTH-1:0] sh_res;
  logic             sh_out;
  logic [SHW-1:0]   sh_n;
  logic [WIDTH:0]   add_r;
  logic [WIDTH:0]   sub_r;
  logic             fin;
  logic [WIDTH-1:0] fin_r;
  logic             fin_c;

  // The first iteration step runs on the acceptance edge straight from the
  // ports, so an n-step operation presents its result n cycles after acceptance.
  assign idle   = (state_q == IDLE);
  assign w_cmd  = idle ? alu_cmd : cmd_q;
  assign w_a    = idle ? inA : a_q;
  assign w_sci  = idle ? sc_i : sci_q;
  assign sh_res = (w_cmd == CMD_SHL) ? {w_a[WIDTH-2:0], w_sci} : {w_sci, w_a[WIDTH-1:1]};
  assign sh_out = (w_cmd == CMD_SHL) ? w_a[WIDTH-1] : w_a[0];
  assign sh_n   = inB[SHW-1:0];
  assign add_r  = {1'b0, inA} + {1'b0, inB} + {{WIDTH{1'b0}}, sc_i};
  assign sub_r  = {1'b0, inA} - {1'b0, inB} + {{WIDTH{1'b0}}, sc_i};

`ifdef SEQ_ALU_MUL_EN
  // Accumulator starts as {0, B}; each step adds A to the high half when the
  // current multiplier bit (LSB) is set, then shifts the whole register right.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     mul_sum;

  assign w_acc   = idle ? {{WIDTH{1'b0}}, inB} : acc_q;
  assign mul_sum = {1'b0, w_acc[2*WIDTH-1:WIDTH]} + (w_acc[0] ? {1'b0, w_a} : '0);
  assign mul_acc = {mul_sum, w_acc[WIDTH-1:1]};
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    a_d     = a_q;
    sci_d   = sci_q;
    cnt_d   = cnt_q;
    rslt_d  = rslt_q;
    sco_d   = sco_q;
    pari_d  = pari_q;
    zero_d  = zero_q;
`ifdef SEQ_ALU_MUL_EN
    acc_d   = acc_q;
`endif
    fin     = 1'b0;
    fin_r   = '0;
    fin_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cmd_d = alu_cmd;
          a_d   = inA;
          sci_d = sc_i;
          case (alu_cmd)
            CMD_ADD: begin
              fin   = 1'b1;
              fin_r = add_r[WIDTH-1:0];
              fin_c = add_r[WIDTH];
            end
            CMD_NAND: begin
              fin   = 1'b1;
              fin_r = ~(inA & inB);
            end
            CMD_SUB: begin
              fin   = 1'b1;
              fin_r = sub_r[WIDTH-1:0];
              fin_c = sub_r[WIDTH];
            end
            CMD_XOR: begin
              fin   = 1'b1;
              fin_r = inA ^ inB;
            end
            CMD_SHL, CMD_SHR: begin
              if (sh_n == '0) begin
                fin   = 1'b1;
                fin_r = inA;
              end else if (sh_n == SHW'(1)) begin
                fin   = 1'b1;
                fin_r = sh_res;
                fin_c = sh_out;
              end else begin
                a_d     = sh_res;
                cnt_d   = sh_n - SHW'(1);
                state_d = EXEC;
              end
            end
`ifdef SEQ_ALU_MUL_EN
            CMD_MUL: begin
              acc_d   = mul_acc;
              cnt_d   = SHW'(WIDTH - 1);
              state_d = EXEC;
            end
`endif
            default: fin = 1'b1;
          endcase
        end
      end
      EXEC: begin
        if (cmd_q != CMD_MUL) a_d = sh_res;
`ifdef SEQ_ALU_MUL_EN
        acc_d = mul_acc;
`endif
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          fin   = 1'b1;
          fin_r = sh_res;
          fin_c = sh_out;
`ifdef SEQ_ALU_MUL_EN
          if (cmd_q == CMD_MUL) begin
            fin_r = mul_acc[WIDTH-1:0];
            fin_c = |mul_acc[2*WIDTH-1:WIDTH];
          end
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flags are derived from the value being registered, never from rslt_q.
    if (fin) begin
      rslt_d  = fin_r;
      sco_d   = fin_c;
      pari_d  = ^fin_r;
      zero_d  = (fin_r == '0);
      state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      a_q     <= '0;
      sci_q   <= 1'b0;
      cnt_q   <= '0;
      rslt_q  <= '0;
      sco_q   <= 1'b0;
      pari_q  <= 1'b0;
      zero_q  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      sci_q   <= sci_d;
      cnt_q   <= cnt_d;
      rslt_q  <= rslt_d;
      sco_q   <= sco_d;
      pari_q  <= pari_d;
      zero_q  <= zero_d;
`ifdef SEQ_ALU_MUL_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign rslt      = rslt_q;
  assign sc_o      = sco_q;
  assign pari      = pari_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8): the driver queues hand-computed
// results, a negedge monitor pops and compares them when out_valid rises.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] alu_cmd;
  logic [7:0] inA;
  logic [7:0] inB;
  logic       sc_i;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] rslt;
  logic       sc_o;
  logic       pari;
  logic       zero;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .sc_i(sc_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .rslt(rslt), .sc_o(sc_o), .pari(pari), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       p;
    logic       z;
    int         lat;
    int         acc;
    int         id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   op_id = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s (op %0d): got %0h, expected %0h", nm, id, act, req);
    end
  endtask

  // Monitor: compare each newly presented result against the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", -1, 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rslt",    mon_e.id, rslt, mon_e.r);
          chk("sc_o",    mon_e.id, sc_o, mon_e.c);
          chk("pari",    mon_e.id, pari, mon_e.p);
          chk("zero",    mon_e.id, zero, mon_e.z);
          chk("latency", mon_e.id, cyc - mon_e.acc, mon_e.lat);
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic issue(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [7:0] er, input logic ec,
                       input logic ep, input logic ez, input int el);
    int n;
    @(negedge clk);
    alu_cmd  = c;
    inA      = a;
    inB      = b;
    sc_i     = s;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    op_id++;
    if (!in_ready) begin
      chk("accept_timeout", op_id, 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      sb.push_back('{r: er, c: ec, p: ep, z: ez, lat: el, acc: cyc, id: op_id});
      @(posedge clk);
      #1 in_valid = 1'b0;
      inA = 8'h00;
      inB = 8'h00;
    end
  endtask

  // Wait for the result, then confirm a single-cycle presentation with out_ready high.
  task automatic finish_op();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    if (!out_valid) begin
      chk("result_timeout", op_id, 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      chk("out_valid_drop", op_id, out_valid, 32'd0);
      chk("in_ready_back",  op_id, in_ready,  32'd1);
    end
  endtask

  task automatic run_op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [7:0] er, input logic ec,
                        input logic ep, input logic ez, input int el);
    issue(c, a, b, s, er, ec, ep, ez, el);
    finish_op();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_cmd   = 3'b000;
    inA       = 8'h00;
    inB       = 8'h00;
    sc_i      = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready",  0, in_ready,  32'd1);
    chk("rst_out_valid", 0, out_valid, 32'd0);
    chk("rst_rslt",      0, rslt,      32'd0);
    chk("rst_flags",     0, {sc_o, pari, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //      cmd     A      B      sc    rslt   sc_o  pari  zero  lat
    run_op(3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1);
    run_op(3'b001, 8'h81, 8'h03, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 3);
    run_op(3'b001, 8'h81, 8'h00, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1);
    run_op(3'b100, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b1, 1'b0, 1);
    run_op(3'b100, 8'h07, 8'h05, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1);
    run_op(3'b000, 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1);
    run_op(3'b110, 8'hA5, 8'h0F, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1);
    run_op(3'b010, 8'h81, 8'h01, 1'b0, 8'h40, 1'b1, 1'b1, 1'b0, 1);
    run_op(3'b010, 8'hF0, 8'h04, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 4);
    run_op(3'b001, 8'h01, 8'h0F, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 7);
    run_op(3'b111, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1);
`ifdef SEQ_ALU_MUL_EN
    run_op(3'b101, 8'h10, 8'h11, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 8);
`else
    run_op(3'b101, 8'h10, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1);
`endif

    // Backpressure: result must be held while requests are offered meanwhile.
    out_ready = 1'b0;
    issue(3'b011, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", op_id, out_valid, 32'd1);
      chk("bp_rslt",      op_id, rslt,      32'd0);
      chk("bp_in_ready",  op_id, in_ready,  32'd0);
      alu_cmd  = 3'b000;
      inA      = 8'h01;
      inB      = 8'h01;
      in_valid = (k % 2 == 0);
    end
    @(negedge clk);
    chk("bp_out_valid_end", op_id, out_valid, 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", op_id, out_valid, 32'd0);
    chk("bp_release_ready", op_id, in_ready,  32'd1);
    repeat (3) @(negedge clk);

    // Reset in the middle of a multiply (EXEC cycle 4 when the multiplier exists).
    run_op(3'b110, 8'hFF, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1);
`ifdef SEQ_ALU_MUL_EN
    issue(3'b101, 8'h10, 8'h11, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 8);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_rslt",  op_id, rslt,     32'hAA);
    chk("pre_reset_ready", op_id, in_ready, 32'd0);
`else
    issue(3'b101, 8'h10, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1);
    repeat (3) @(posedge clk);
    #2;
`endif
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", op_id, out_valid, 32'd0);
    chk("mid_rst_rslt",      op_id, rslt,      32'd0);
    chk("mid_rst_flags",     op_id, {sc_o, pari, zero}, 32'd0);
    chk("mid_rst_in_ready",  op_id, in_ready,  32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", op_id, {out_valid, in_ready}, 32'd1);
    run_op(3'b000, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1, 1'b0, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", op_id, sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
